// File: rtl/stall_aware_producer_if.sv
// Handshake bundle between the stall-aware producer and the dual-lane pipeline.
// master = producer side, slave = pipeline side.
interface stall_aware_producer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic              stall_1;
  logic              stall_2;
  logic [DATA_W-1:0] pipeline1_inputs;
  logic [DATA_W-1:0] pipeline2_inputs;
  logic [1:0]        in_valid;
  logic              flush_1;
  logic              flush_2;
  logic              done;

  modport master (
    input  start, stall_1, stall_2,
    output pipeline1_inputs, pipeline2_inputs, in_valid, flush_1, flush_2, done
  );

  modport slave (
    output start, stall_1, stall_2,
    input  pipeline1_inputs, pipeline2_inputs, in_valid, flush_1, flush_2, done
  );
endinterface

// File: rtl/stall_aware_producer.sv
// Dual-lane, stall-correct, count-bounded stimulus producer with periodic flush pulses.
// Define PRODUCER_BUBBLE_EN to add per-lane LFSR-driven bubble insertion.
module stall_aware_producer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_TXN      = 16,
  parameter int unsigned FLUSH_PERIOD = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  stall_aware_producer_if.master bus
);
  localparam int unsigned SEQ_W  = DATA_W - 4;
  localparam int unsigned FP_DIV = (FLUSH_PERIOD == 0) ? 1 : FLUSH_PERIOD;

  typedef enum logic [1:0] {IDLE, SEND, FLUSH, DONE} lane_state_e;

  lane_state_e       state_q [2];
  lane_state_e       state_d [2];
  logic [SEQ_W-1:0]  seq_q   [2];
  logic [SEQ_W-1:0]  seq_d   [2];
  logic [SEQ_W:0]    cnt     [2];
  logic [DATA_W-1:0] data_q  [2];
  logic [DATA_W-1:0] data_d  [2];
  logic [1:0]        valid_q, valid_d;
  logic [1:0]        flush_q, flush_d;
  logic [1:0]        stall;
  logic [1:0]        bubble;
  logic              done_q, done_d;
  logic              armed_q;
  logic              start_ok;
`ifdef PRODUCER_BUBBLE_EN
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  logic [7:0] lfsr_q [2];
  logic [7:0] lfsr_d [2];
  logic [1:0] bub_q, bub_d;
`endif

  assign stall = {bus.stall_2, bus.stall_1};

  // armed_q blocks a start sampled on the first edge after reset release
  assign start_ok = armed_q && bus.start &&
                    (state_q[0] inside {IDLE, DONE}) &&
                    (state_q[1] inside {IDLE, DONE});

  always_comb begin
    done_d = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      seq_d[i]   = seq_q[i];
      cnt[i]     = {1'b0, seq_q[i]} + 1'b1;
`ifdef PRODUCER_BUBBLE_EN
      lfsr_d[i]  = lfsr_q[i];
      bub_d[i]   = bub_q[i];
`endif
      unique case (state_q[i])
        IDLE, DONE: begin
          if (start_ok) begin
            state_d[i] = SEND;
            seq_d[i]   = '0;
`ifdef PRODUCER_BUBBLE_EN
            lfsr_d[i]  = (i == 0) ? 8'hA5 : 8'h3C;
            bub_d[i]   = 1'b0;
`endif
          end
        end
        SEND: begin
          if (valid_q[i] && !stall[i]) begin
            seq_d[i] = cnt[i][SEQ_W-1:0];
            if (32'(cnt[i]) == NUM_TXN) begin
              state_d[i] = DONE;
            end else if (FLUSH_PERIOD != 0 && (32'(cnt[i]) % FP_DIV) == 0) begin
              state_d[i] = FLUSH;
            end
`ifdef PRODUCER_BUBBLE_EN
            // a pending bubble survives a FLUSH and is taken on return to SEND
            lfsr_d[i] = {1'b0, lfsr_q[i][7:1]} ^ (lfsr_q[i][0] ? LFSR_TAPS : 8'h00);
            bub_d[i]  = lfsr_d[i][0];
          end else if (!valid_q[i]) begin
            bub_d[i]  = 1'b0;
`endif
          end
        end
        FLUSH:   state_d[i] = SEND;
        default: state_d[i] = IDLE;
      endcase
`ifdef PRODUCER_BUBBLE_EN
      bubble[i] = bub_d[i];
`else
      bubble[i] = 1'b0;
`endif
      valid_d[i] = (state_d[i] == SEND) && !bubble[i];
      flush_d[i] = (state_d[i] == FLUSH);
      data_d[i]  = valid_d[i] ? {4'(i + 1), seq_d[i]} : '0;
    end
    done_d = (state_d[0] == DONE) && (state_d[1] == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        seq_q[i]   <= '0;
        data_q[i]  <= '0;
`ifdef PRODUCER_BUBBLE_EN
        lfsr_q[i]  <= (i == 0) ? 8'hA5 : 8'h3C;
`endif
      end
`ifdef PRODUCER_BUBBLE_EN
      bub_q   <= '0;
`endif
      valid_q <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        seq_q[i]   <= seq_d[i];
        data_q[i]  <= data_d[i];
`ifdef PRODUCER_BUBBLE_EN
        lfsr_q[i]  <= lfsr_d[i];
`endif
      end
`ifdef PRODUCER_BUBBLE_EN
      bub_q   <= bub_d;
`endif
      valid_q <= valid_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end

  assign bus.pipeline1_inputs = data_q[0];
  assign bus.pipeline2_inputs = data_q[1];
  assign bus.in_valid         = valid_q;
  assign bus.flush_1          = flush_q[0];
  assign bus.flush_2          = flush_q[1];
  assign bus.done             = done_q;
endmodule

// File: tb/tb_stall_aware_producer.sv
// Self-checking bench for stall_aware_producer: directed scenarios plus random stalls/starts,
// compared every cycle against a beat-counting reference model.
module tb_stall_aware_producer;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 16;
  localparam int unsigned FP = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stall_aware_producer_if #(.DATA_W(DW)) bus ();

  stall_aware_producer #(.DATA_W(DW), .NUM_TXN(N), .FLUSH_PERIOD(FP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  // Reference model: per lane, running flag, beats accepted, and flush-cycle flag.
  bit          m_armed;
  bit          m_done;
  bit          m_run   [2];
  bit          m_flush [2];
  int unsigned m_cnt   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic exp_valid(input int unsigned i);
    return m_run[i] && !m_flush[i];
  endfunction

  function automatic logic [DW-1:0] exp_data(input int unsigned i);
    logic [3:0]    id;
    logic [DW-5:0] s;
    id = 4'(i + 1);
    s  = (DW-4)'(m_cnt[i]);
    return exp_valid(i) ? {id, s} : '0;
  endfunction

  task automatic model_reset();
    m_armed = 1'b0;
    m_done  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_run[i]   = 1'b0;
      m_flush[i] = 1'b0;
      m_cnt[i]   = 0;
    end
  endtask

  task automatic model_edge(input logic st, input logic s1, input logic s2);
    bit busy;
    bit stl;
    busy = m_run[0] || m_run[1];
    if (st && m_armed && !busy) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]   = 1'b1;
        m_flush[i] = 1'b0;
        m_cnt[i]   = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        stl = (i == 0) ? s1 : s2;
        if (m_flush[i]) begin
          m_flush[i] = 1'b0;
        end else if (m_run[i] && !stl) begin
          m_cnt[i]++;
          if (m_cnt[i] == N) m_run[i] = 1'b0;
          else if (FP != 0 && (m_cnt[i] % FP) == 0) m_flush[i] = 1'b1;
        end
      end
    end
    m_done  = !m_run[0] && !m_run[1] && (m_cnt[0] == N) && (m_cnt[1] == N);
    m_armed = 1'b1;
  endtask

  task automatic compare_all();
    check("in_valid", 32'(bus.in_valid), 32'({exp_valid(1), exp_valid(0)}));
    check("flush_1", 32'(bus.flush_1), 32'(m_flush[0]));
    check("flush_2", 32'(bus.flush_2), 32'(m_flush[1]));
    check("data_1", bus.pipeline1_inputs, exp_data(0));
    check("data_2", bus.pipeline2_inputs, exp_data(1));
    check("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic step();
    logic st, s1, s2;
    st = bus.start;
    s1 = bus.stall_1;
    s2 = bus.stall_2;
    @(posedge clk);
    if (reset) model_edge(st, s1, s2);
    #1;
    compare_all();
  endtask

  initial begin : main
    int unsigned n;
    bus.start   = 1'b0;
    bus.stall_1 = 1'b0;
    bus.stall_2 = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    #1 compare_all();
    repeat (2) @(posedge clk);

    // start held across reset release must be ignored
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (20) step();

    // full run, no stalls: done latency and stickiness
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("done_latency", n, 19);
    repeat (3) step();

    // restart after done
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_data_1", bus.pipeline1_inputs, 32'h1000_0000);
    check("restart_data_2", bus.pipeline2_inputs, 32'h2000_0000);
    check("restart_done_clear", 32'(bus.done), 32'd0);
    step();
    step();

    // lane 1 stalled 5 cycles on seq 2, with a mid-run start that must be ignored
    bus.stall_1 = 1'b1;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    repeat (4) step();
    check("hold_data_1", bus.pipeline1_inputs, 32'h1000_0002);
    bus.stall_1 = 1'b0;

    // stall_2 high through lane 2's flush cycle
    n = 0;
    while (!m_flush[1] && n < 20) begin
      step();
      n++;
    end
    check("flush_2_seen", 32'(bus.flush_2), 32'd1);
    check("flush_2_valid_low", 32'(bus.in_valid[1]), 32'd0);
    bus.stall_2 = 1'b1;
    step();
    step();
    bus.stall_2 = 1'b0;
    n = 0;
    while (!m_done && n < 200) begin
      step();
      n++;
    end
    check("run2_finished", 32'(n < 200), 32'd1);

    // random stalls and start pulses
    for (int c = 0; c < 600; c++) begin
      bus.stall_1 = ($urandom_range(0, 3) == 0);
      bus.stall_2 = ($urandom_range(0, 2) == 0);
      bus.start   = ($urandom_range(0, 11) == 0);
      step();
    end
    bus.start   = 1'b0;
    bus.stall_1 = 1'b0;
    bus.stall_2 = 1'b0;
    n = 0;
    while ((m_run[0] || m_run[1]) && n < 100) begin
      step();
      n++;
    end
    check("random_drain", 32'(n < 100), 32'd1);

    // reset mid-run at seq 5
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (m_cnt[0] != 5 && n < 40) begin
      step();
      n++;
    end
    check("reach_seq5", bus.pipeline1_inputs, 32'h1000_0005);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("post_reset_data_1", bus.pipeline1_inputs, 32'h1000_0000);
    check("post_reset_data_2", bus.pipeline2_inputs, 32'h2000_0000);
    n = 0;
    while (!m_done && n < 60) begin
      step();
      n++;
    end
    check("final_done", 32'(bus.done), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/stall_aware_producer.md
Name: stall_aware_producer

Overview:
- Upstream stimulus source for the dual-lane pipeline block with arbiter and shared resource.
- Drives two independent 32-bit input streams with per-lane valid and periodic flush pulses.
- Obeys the per-lane stall signals fed back from the pipeline block.
- Replaces the free-running producer FSM with a stall-correct, count-bounded generator that reports completion.

Parameters:
- DATA_W, 32, width of each lane's data word; top 4 bits carry the lane tag.
- NUM_TXN, 16, beats accepted per lane before that lane finishes (1..2^(DATA_W-4)).
- FLUSH_PERIOD, 4, flush pulse after every FLUSH_PERIOD accepted beats; 0 disables flush.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run when both lanes are IDLE or DONE.
- stall_1  in  1  lane-1 back-pressure from the pipeline.
- stall_2  in  1  lane-2 back-pressure from the pipeline.
- pipeline1_inputs  out  DATA_W  lane-1 data.
- pipeline2_inputs  out  DATA_W  lane-2 data.
- in_valid  out  2  bit0 = lane 1 valid, bit1 = lane 2 valid.
- flush_1  out  1  lane-1 flush pulse.
- flush_2  out  1  lane-2 flush pulse.
- done  out  1  high when both lanes are DONE; sticky until the next accepted start.

Behaviour:
- Reset (reset=0, async): every output is 0 immediately. Lane FSMs go to IDLE and sequence counters to 0. Reset mid-run aborts the run with no beat completed.
- Each lane runs an independent FSM, states IDLE, SEND, FLUSH, DONE. Lanes share only start and done.
- Transfer: a beat on lane i is accepted on a rising edge where in_valid[i]=1 and stall_i=0.
- Hold rule: while in_valid[i]=1 and stall_i=1, data and valid hold bit-stable.
- Data word: {lane_id[3:0], seq[DATA_W-5:0]}. lane_id is 4'h1 for lane 1 and 4'h2 for lane 2. seq = number of beats already accepted on that lane (0..NUM_TXN-1). No wrap within a run.
- IDLE: valid=0, flush=0. On start, go to SEND with seq=0.
- SEND: valid=1. On acceptance, seq increments, then:
  - if seq+1 == NUM_TXN, go to DONE;
  - else if FLUSH_PERIOD != 0 and (seq+1) % FLUSH_PERIOD == 0, go to FLUSH;
  - else stay in SEND; the next beat is presented in the following cycle, giving back-to-back beats.
- FLUSH: exactly one cycle with flush_i=1 and in_valid[i]=0, then back to SEND. Flush ignores stall_i and is never delayed. seq is not cleared by flush.
- DONE: valid=0, flush=0. done=1 in the cycle after the later lane enters DONE (registered).
- start while either lane is in SEND or FLUSH: ignored, no state change.
- start while both lanes are DONE: clear done and restart both lanes at seq=0 next cycle.
- start asserted in the same cycle as reset deassertion: ignored.
- Stalls on one lane never affect the other lane's timing.
- All outputs are registered; no combinational path from stall_i to outputs.
- Latency: first beat valid one cycle after start is sampled.

Optional Feature:
- Macro: PRODUCER_BUBBLE_EN.
- With the macro: one 8-bit Galois LFSR per lane (seeds 8'hA5 lane 1, 8'h3C lane 2, polynomial x^8+x^6+x^5+x^4+1). The LFSR advances on every accepted beat of its lane. If the post-advance LFSR bit0=1, the lane inserts one bubble cycle (valid=0) before the next beat. A bubble never replaces or delays a FLUSH; it follows it.
- Without the macro: no LFSR logic; beats are back-to-back whenever stall allows.

Test Plan:
- Reset release, no start, 20 cycles -> in_valid=2'b00, flush_1=flush_2=0, done=0, data=0 throughout.
- NUM_TXN=16, FLUSH_PERIOD=4, stalls low, start pulse -> lane 1 emits 32'h1000_0000..32'h1000_000F. flush_1 pulses after beats 3, 7 and 11 only. done rises 19 cycles after start (16 beats + 3 flush cycles) and stays high.
- stall_1 held high 5 cycles while lane 1 presents 32'h1000_0002 -> data and valid stable all 5 cycles, beat counted once. Lane 2 continues unstalled, unaffected.
- stall_2 high in the cycle lane 2 is due to flush -> flush_2 still pulses one cycle, in_valid[1]=0 that cycle.
- reset asserted low mid-run at seq=5 -> outputs 0 immediately. After release and start, both lanes restart at seq 0.
- Second start while running (cycle 3) -> ignored. Start after done=1 -> done clears and sequence restarts at 32'h1000_0000 / 32'h2000_0000.
